hdlc_rx_bank_ctrl: RTL and testbench

- Ping-pong buffer controller for the HDLC receive RAM.
- Splits the RAM into two 256-byte banks and steers the receiver's write bank.
- Tracks which banks hold frames not yet read, and reports frame length and status to the DSP over EMIF.
- Raises the DSP receive interrupt; the DSP releases banks by writing an ACK register.

---
 rtl/hdlc_rx_bank_ctrl.sv | 155 +++++++++++++++
 tb/tb_hdlc_rx_bank_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_bank_ctrl.sv
// hdlc_rx_bank_ctrl: ping-pong bank steering, DSP status/ACK registers and receive interrupt
// for the HDLC receive RAM.
module hdlc_rx_bank_ctrl #(
    parameter logic [23:0] ACK_ADDR  = 24'h000100,
    parameter logic [23:0] STAT_ADDR = 24'h000101,
    parameter int          IRQ_PULSE = 100
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    input  logic        rx_eof_async,
    input  logic [8:0]  rx_len_in,
    output logic        rx_bank,
    output logic        rx_enable,
    input  logic        emif_wen,
    input  logic        emif_ren,
    input  logic [23:0] emif_addr,
    input  logic [15:0] emif_wdata,
    output logic        stat_sel,
    output logic [15:0] stat_rdata,
    output logic        irq,
    output logic [7:0]  ovf_cnt
);
    localparam int CW = $clog2(IRQ_PULSE + 1);

    typedef enum logic {RUN, STALL} state_t;
    state_t state, state_n;

    logic eof_m, eof_q, eof_d, eof_p, eof_d1, eof_s;
    logic [8:0] len_m, len_q, len0, len1, len0_n, len1_n;
    logic wr_bank, rd_bank, wr_n, rd_n;
    logic [1:0] full, full_n;
    logic [7:0] ovf_n;
    logic ack, ack_ok, clr, irq_ev, pend, gap;
    logic [CW-1:0] irq_cnt;
    logic unused_wdata;

    assign unused_wdata = ^emif_wdata[15:2];
    assign eof_p  = eof_q & ~eof_d;
    assign ack    = emif_wen && emif_addr == ACK_ADDR && emif_wdata[0];
    assign clr    = emif_wen && emif_addr == ACK_ADDR && emif_wdata[1];
    assign ack_ok = ack && full[rd_bank];

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            eof_m  <= 1'b0;
            eof_q  <= 1'b0;
            eof_d  <= 1'b0;
            eof_d1 <= 1'b0;
            eof_s  <= 1'b0;
            len_m  <= '0;
            len_q  <= '0;
        end else begin
            eof_m  <= rx_eof_async;
            eof_q  <= eof_m;
            eof_d  <= eof_q;
            eof_d1 <= eof_p;
            eof_s  <= eof_d1;
            len_m  <= rx_len_in;
            len_q  <= len_m;
        end
    end

    // The ACK is resolved first so a same-cycle eof sees the bank it frees.
    always_comb begin
        state_n = state;
        full_n  = full;
        rd_n    = rd_bank;
        wr_n    = wr_bank;
        len0_n  = len0;
        len1_n  = len1;
        ovf_n   = clr ? 8'd0 : ovf_cnt;
        if (ack_ok) begin
            full_n[rd_bank] = 1'b0;
            rd_n = ~rd_bank;
            if (state == STALL) begin
                state_n = RUN;
                wr_n    = rd_bank;
            end
        end
        if (eof_s) begin
            if (state_n == STALL) begin
                ovf_n = (ovf_n == 8'hFF) ? ovf_n : ovf_n + 8'd1;
            end else begin
                if (wr_n) len1_n = len_q;
                else      len0_n = len_q;
                full_n[wr_n] = 1'b1;
                if (full_n[~wr_n]) state_n = STALL;
                else               wr_n = ~wr_n;
            end
        end
        irq_ev = (|(full_n & ~full)) || (ack_ok && full[~rd_bank]);
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            len0      <= '0;
            len1      <= '0;
            ovf_cnt   <= '0;
            rx_bank   <= 1'b0;
            rx_enable <= 1'b1;
        end else begin
            state     <= state_n;
            full      <= full_n;
            wr_bank   <= wr_n;
            rd_bank   <= rd_n;
            len0      <= len0_n;
            len1      <= len1_n;
            ovf_cnt   <= ovf_n;
            rx_bank   <= wr_n;
            rx_enable <= state_n == RUN;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            stat_sel   <= 1'b0;
            stat_rdata <= '0;
        end else begin
            stat_sel <= emif_ren && emif_addr == STAT_ADDR;
            if (emif_ren && emif_addr == STAT_ADDR)
                stat_rdata <= {full[rd_bank], rd_bank, state == STALL, full[~rd_bank], 3'b000,
                               rd_bank ? len1 : len0};
        end
    end

    // Events during a pulse are remembered; gap forces one low cycle before the re-fire.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            irq     <= 1'b0;
            irq_cnt <= '0;
            pend    <= 1'b0;
            gap     <= 1'b0;
        end else if (gap) begin
            gap     <= 1'b0;
            irq     <= 1'b1;
            irq_cnt <= CW'(IRQ_PULSE);
            pend    <= irq_ev;
        end else if (irq) begin
            irq_cnt <= irq_cnt - CW'(1);
            pend    <= pend | irq_ev;
            if (irq_cnt == CW'(1)) begin
                irq  <= 1'b0;
                gap  <= pend | irq_ev;
                pend <= 1'b0;
            end
        end else if (irq_ev) begin
            irq     <= 1'b1;
            irq_cnt <= CW'(IRQ_PULSE);
        end
    end
endmodule

// File: tb/tb_hdlc_rx_bank_ctrl.sv
// tb_hdlc_rx_bank_ctrl: scenario tasks plus randomized traffic checked against a
// transaction-level model of the bank controller.
module tb_hdlc_rx_bank_ctrl;
    localparam logic [23:0] ACK_ADDR  = 24'h000100;
    localparam logic [23:0] STAT_ADDR = 24'h000101;

    logic        clk_100m = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_eof_async = 1'b0;
    logic [8:0]  rx_len_in = '0;
    logic        emif_wen = 1'b0;
    logic        emif_ren = 1'b0;
    logic [23:0] emif_addr = '0;
    logic [15:0] emif_wdata = '0;
    logic        rx_bank, rx_enable, stat_sel, irq;
    logic [15:0] stat_rdata;
    logic [7:0]  ovf_cnt;

    int n_cmp = 0;
    int n_err = 0;

    bit         m_wr, m_rd, m_stall;
    bit [1:0]   m_full;
    logic [8:0] m_len [2];
    int         m_ovf;

    hdlc_rx_bank_ctrl dut (
        .clk_100m(clk_100m), .rst_n(rst_n), .rx_eof_async(rx_eof_async), .rx_len_in(rx_len_in),
        .rx_bank(rx_bank), .rx_enable(rx_enable), .emif_wen(emif_wen), .emif_ren(emif_ren),
        .emif_addr(emif_addr), .emif_wdata(emif_wdata), .stat_sel(stat_sel),
        .stat_rdata(stat_rdata), .irq(irq), .ovf_cnt(ovf_cnt)
    );

    always #5 clk_100m = ~clk_100m;

    function automatic void m_reset();
        m_wr = 0; m_rd = 0; m_stall = 0; m_full = 2'b00; m_len[0] = 0; m_len[1] = 0; m_ovf = 0;
    endfunction

    function automatic void m_ack(input logic [15:0] d);
        if (d[0] && m_full[m_rd]) begin
            m_full[m_rd] = 0;
            if (m_stall) begin
                m_stall = 0;
                m_wr = m_rd;
            end
            m_rd = !m_rd;
        end
        if (d[1]) m_ovf = 0;
    endfunction

    function automatic void m_eof(input logic [8:0] len);
        if (m_stall) begin
            if (m_ovf < 255) m_ovf++;
        end else begin
            m_len[m_wr] = len;
            m_full[m_wr] = 1;
            if (m_full[!m_wr]) m_stall = 1;
            else m_wr = !m_wr;
        end
    endfunction

    function automatic logic [15:0] m_stat();
        return {m_full[m_rd], m_rd, m_stall, m_full[!m_rd], 3'b000, m_len[m_rd]};
    endfunction

    task automatic do_reset();
        rst_n = 0; rx_eof_async = 0; emif_wen = 0; emif_ren = 0;
        repeat (3) @(negedge clk_100m);
        rst_n = 1;
        m_reset();
        @(negedge clk_100m);
    endtask

    task automatic emif_write(input logic [23:0] a, input logic [15:0] d);
        @(negedge clk_100m);
        emif_wen = 1; emif_addr = a; emif_wdata = d;
        @(negedge clk_100m);
        emif_wen = 0;
    endtask

    task automatic emif_read(input logic [23:0] a, output logic s0, output logic s1,
                             output logic s2, output logic [15:0] rd);
        @(negedge clk_100m);
        emif_ren = 1; emif_addr = a;
        s0 = stat_sel;
        @(negedge clk_100m);
        emif_ren = 0;
        s1 = stat_sel; rd = stat_rdata;
        @(negedge clk_100m);
        s2 = stat_sel;
    endtask

    task automatic frame(input logic [8:0] len, input int hi, input int lo,
                         input bit ack_mid, input logic [15:0] ackd);
        @(negedge clk_100m);
        rx_len_in = len; rx_eof_async = 1;
        if (ack_mid) begin
            repeat (4) @(posedge clk_100m);
            @(negedge clk_100m);
            emif_wen = 1; emif_addr = ACK_ADDR; emif_wdata = ackd;
            @(negedge clk_100m);
            emif_wen = 0;
        end
        repeat (hi) @(negedge clk_100m);
        rx_eof_async = 0;
        repeat (lo) @(negedge clk_100m);
        if (ack_mid) m_ack(ackd);
        m_eof(len);
    endtask

    task automatic measure_run(input logic level, output int n);
        n = 0;
        while (irq === level && n < 400) begin
            n++;
            @(negedge clk_100m);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk_100m);
        n_cmp++; if ({rx_bank, rx_enable, stat_sel, irq} !== 4'b0100) begin n_err++;
            $display("FAIL reset_bits: got %b want 0100", {rx_bank, rx_enable, stat_sel, irq}); end
        n_cmp++; if (stat_rdata !== 16'h0000) begin n_err++;
            $display("FAIL reset_stat: got %h want 0000", stat_rdata); end
        n_cmp++; if (ovf_cnt !== 8'h00) begin n_err++;
            $display("FAIL reset_ovf: got %h want 00", ovf_cnt); end
        do_reset();
    endtask

    task automatic test_single_frame();
        int k, h;
        logic s0, s1, s2;
        logic [15:0] rd;
        do_reset();
        @(negedge clk_100m);
        rx_len_in = 9'd37; rx_eof_async = 1;
        k = 0;
        while (irq !== 1'b1 && k < 20) begin
            @(negedge clk_100m);
            k++;
        end
        n_cmp++; if (k !== 5) begin n_err++;
            $display("FAIL irq_latency: got %0d cycles want 5", k); end
        measure_run(1'b1, h);
        n_cmp++; if (h !== 100) begin n_err++;
            $display("FAIL irq_width: got %0d want 100", h); end
        rx_eof_async = 0;
        repeat (100) @(negedge clk_100m);
        m_eof(9'd37);
        n_cmp++; if (rx_bank !== 1'b1) begin n_err++;
            $display("FAIL single_rx_bank: got %b want 1", rx_bank); end
        emif_read(STAT_ADDR, s0, s1, s2, rd);
        n_cmp++; if ({s0, s1, s2} !== 3'b010) begin n_err++;
            $display("FAIL single_stat_sel: got %b want 010", {s0, s1, s2}); end
        n_cmp++; if (rd !== 16'h8025 || rd !== m_stat()) begin n_err++;
            $display("FAIL single_stat: got %h want 8025 (model %h)", rd, m_stat()); end
    endtask

    task automatic test_ping_pong();
        int h;
        logic s0, s1, s2;
        logic [15:0] rd;
        do_reset();
        frame(9'd10, 50, 160, 0, 0);
        frame(9'd20, 50, 160, 0, 0);
        n_cmp++; if (irq !== 1'b0) begin n_err++;
            $display("FAIL pp_irq_idle: got %b want 0", irq); end
        emif_write(ACK_ADDR, 16'h0001);
        m_ack(16'h0001);
        n_cmp++; if (irq !== 1'b1) begin n_err++;
            $display("FAIL pp_irq_refire: got %b want 1", irq); end
        measure_run(1'b1, h);
        n_cmp++; if (h !== 100) begin n_err++;
            $display("FAIL pp_irq_width: got %0d want 100", h); end
        emif_read(STAT_ADDR, s0, s1, s2, rd);
        n_cmp++; if (rd !== 16'hC014 || rd !== m_stat()) begin n_err++;
            $display("FAIL pp_stat1: got %h want C014 (model %h)", rd, m_stat()); end
        emif_write(ACK_ADDR, 16'h0001);
        m_ack(16'h0001);
        emif_read(STAT_ADDR, s0, s1, s2, rd);
        n_cmp++; if (rd !== m_stat() || rd[15] !== 1'b0) begin n_err++;
            $display("FAIL pp_stat2: got %h want %h", rd, m_stat()); end
        n_cmp++; if (rx_enable !== 1'b1) begin n_err++;
            $display("FAIL pp_rx_enable: got %b want 1", rx_enable); end
    endtask

    task automatic test_irq_pending();
        int h1, l, h2;
        do_reset();
        frame(9'd5, 50, 160, 0, 0);
        frame(9'd6, 50, 160, 0, 0);
        emif_write(ACK_ADDR, 16'h0001);
        rx_len_in = 9'd7; rx_eof_async = 1;
        measure_run(1'b1, h1);
        measure_run(1'b0, l);
        measure_run(1'b1, h2);
        n_cmp++; if (h1 !== 100 || l !== 1 || h2 !== 100) begin n_err++;
            $display("FAIL irq_pending: got %0d/%0d/%0d want 100/1/100", h1, l, h2); end
        rx_eof_async = 0;
        repeat (20) @(negedge clk_100m);
        m_ack(16'h0001);
        m_eof(9'd7);
        n_cmp++; if (rx_enable !== !m_stall) begin n_err++;
            $display("FAIL pending_rx_enable: got %b want %b", rx_enable, !m_stall); end
    endtask

    task automatic test_overflow();
        logic s0, s1, s2;
        logic [15:0] rd;
        do_reset();
        frame(9'd100, 50, 160, 0, 0);
        frame(9'd200, 50, 160, 0, 0);
        for (int i = 0; i < 3; i++) frame(9'($urandom), 50, 160, 0, 0);
        n_cmp++; if (rx_enable !== 1'b0 || ovf_cnt !== 8'd3) begin n_err++;
            $display("FAIL ovf_stall: got en=%b ovf=%0d want en=0 ovf=3", rx_enable, ovf_cnt); end
        emif_read(STAT_ADDR, s0, s1, s2, rd);
        n_cmp++; if (rd[13] !== 1'b1 || rd !== m_stat()) begin n_err++;
            $display("FAIL ovf_stat: got %h want %h", rd, m_stat()); end
        emif_write(ACK_ADDR, 16'h0001);
        m_ack(16'h0001);
        n_cmp++; if (rx_enable !== 1'b1 || rx_bank !== 1'b0) begin n_err++;
            $display("FAIL ovf_ack: got en=%b bank=%b want en=1 bank=0", rx_enable, rx_bank); end
        emif_write(ACK_ADDR, 16'h0003);
        m_ack(16'h0003);
        n_cmp++; if (ovf_cnt !== 8'd0) begin n_err++;
            $display("FAIL ovf_clear: got %0d want 0", ovf_cnt); end
        frame(9'd1, 50, 160, 0, 0);
        for (int i = 0; i < 260; i++) frame(9'd1, 50, 10, 0, 0);
        n_cmp++; if (ovf_cnt !== 8'(m_ovf) || ovf_cnt !== 8'hFF) begin n_err++;
            $display("FAIL ovf_saturate: got %0d want 255", ovf_cnt); end
    endtask

    task automatic test_simultaneous();
        logic s0, s1, s2;
        logic [15:0] rd;
        do_reset();
        frame(9'd10, 50, 160, 0, 0);
        frame(9'd55, 50, 160, 1, 16'h0001);
        n_cmp++; if (rx_enable !== 1'b1 || ovf_cnt !== 8'd0 || rx_bank !== 1'b0) begin n_err++;
            $display("FAIL simul_run: got en=%b ovf=%0d bank=%b want 1/0/0", rx_enable, ovf_cnt, rx_bank); end
        emif_read(STAT_ADDR, s0, s1, s2, rd);
        n_cmp++; if (rd !== 16'hC037 || rd !== m_stat()) begin n_err++;
            $display("FAIL simul_stat: got %h want C037", rd); end
        frame(9'd66, 50, 160, 0, 0);
        frame(9'd77, 50, 160, 1, 16'h0001);
        emif_read(STAT_ADDR, s0, s1, s2, rd);
        n_cmp++; if (rd !== m_stat() || ovf_cnt !== 8'(m_ovf) || rx_enable !== !m_stall) begin n_err++;
            $display("FAIL simul_stall: got %h ovf=%0d en=%b want %h ovf=%0d en=%b",
                     rd, ovf_cnt, rx_enable, m_stat(), m_ovf, !m_stall); end
    endtask

    task automatic test_spurious();
        logic s0, s1, s2;
        logic [15:0] rd, prev;
        do_reset();
        emif_write(ACK_ADDR, 16'h0001);
        m_ack(16'h0001);
        emif_read(STAT_ADDR, s0, s1, s2, rd);
        n_cmp++; if (rd !== 16'h0000 || rx_bank !== 1'b0) begin n_err++;
            $display("FAIL spur_empty_ack: got %h bank=%b want 0000 bank=0", rd, rx_bank); end
        frame(9'd99, 50, 160, 0, 0);
        emif_write(ACK_ADDR + 24'd2, 16'h0003);
        emif_write(STAT_ADDR, 16'h0001);
        emif_read(STAT_ADDR, s0, s1, s2, prev);
        n_cmp++; if (prev !== 16'h8063 || prev !== m_stat()) begin n_err++;
            $display("FAIL spur_write: got %h want 8063", prev); end
        emif_read(STAT_ADDR + 24'd1, s0, s1, s2, rd);
        n_cmp++; if ({s0, s1, s2} !== 3'b000 || rd !== prev) begin n_err++;
            $display("FAIL spur_read: got sel=%b data=%h want 000 %h", {s0, s1, s2}, rd, prev); end
        emif_read(ACK_ADDR, s0, s1, s2, rd);
        n_cmp++; if (s1 !== 1'b0) begin n_err++;
            $display("FAIL spur_read_ack: got sel=%b want 0", s1); end
    endtask

    task automatic test_reset_mid();
        logic s0, s1, s2;
        logic [15:0] rd;
        do_reset();
        frame(9'd12, 50, 160, 0, 0);
        emif_read(STAT_ADDR, s0, s1, s2, rd);
        @(negedge clk_100m);
        rx_len_in = 9'd200; rx_eof_async = 1;
        repeat (10) @(negedge clk_100m);
        n_cmp++; if (irq !== 1'b1 || rx_enable !== 1'b0) begin n_err++;
            $display("FAIL rstmid_pre: got irq=%b en=%b want 1/0", irq, rx_enable); end
        #1 rst_n = 0;
        #1;
        n_cmp++; if ({rx_bank, rx_enable, stat_sel, irq} !== 4'b0100 || stat_rdata !== 16'h0
                     || ovf_cnt !== 8'h0) begin n_err++;
            $display("FAIL rstmid_async: got %b %h %h want 0100 0000 00",
                     {rx_bank, rx_enable, stat_sel, irq}, stat_rdata, ovf_cnt); end
        rx_eof_async = 0;
        repeat (3) @(negedge clk_100m);
        rst_n = 1;
        m_reset();
        frame(9'd300, 50, 160, 0, 0);
        emif_read(STAT_ADDR, s0, s1, s2, rd);
        n_cmp++; if (rd !== 16'h812C || rd !== m_stat() || rx_bank !== 1'b1) begin n_err++;
            $display("FAIL rstmid_fresh: got %h bank=%b want 812C bank=1", rd, rx_bank); end
    endtask

    task automatic test_random();
        logic s0, s1, s2;
        logic [15:0] rd, d;
        logic [23:0] a;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: frame(9'($urandom), 50, 160, 0, 0);
                1: begin
                    d = 16'($urandom);
                    emif_write(ACK_ADDR, d);
                    m_ack(d);
                end
                2: begin
                    emif_read(STAT_ADDR, s0, s1, s2, rd);
                    n_cmp++; if ({s0, s1, s2} !== 3'b010 || rd !== m_stat()) begin n_err++;
                        $display("FAIL rand_stat[%0d]: got sel=%b %h want 010 %h",
                                 i, {s0, s1, s2}, rd, m_stat()); end
                end
                default: begin
                    a = ACK_ADDR + 24'($urandom_range(2, 40));
                    emif_write(a, 16'hFFFF);
                    emif_read(a, s0, s1, s2, rd);
                    n_cmp++; if (s1 !== 1'b0) begin n_err++;
                        $display("FAIL rand_spur[%0d]: got sel=%b want 0", i, s1); end
                end
            endcase
            n_cmp++; if (rx_enable !== !m_stall || rx_bank !== m_wr || ovf_cnt !== 8'(m_ovf)) begin
                n_err++;
                $display("FAIL rand_state[%0d]: got en=%b bank=%b ovf=%0d want %b %b %0d",
                         i, rx_enable, rx_bank, ovf_cnt, !m_stall, m_wr, m_ovf); end
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_frame();
        test_ping_pong();
        test_irq_pending();
        test_overflow();
        test_simultaneous();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
